alu_exec_unit: RTL and testbench

- Execute stage fed directly by the ALU-control decoder. Consumes the 5-bit ALU operation code and the Sign flag, plus two 32-bit operands.
- Produces the result, a zero flag and a signed-overflow flag.
- Shifts run on an iterative serial shifter, so the block has a multi-cycle path and a valid/ready handshake on both input and output.
- Sits between the decode/operand-select logic and the memory/write-back path.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/serial_shifter.sv | 55 +++++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 tb/tb_alu_exec_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants (also used by the ALU-control decoder),
// datapath width and the execute-stage state encoding.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] ALU_NULL = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_SLT  = 5'd10;
  localparam logic [4:0] ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_LUI  = 5'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_shifter.sv
// Iterative shifter: moves the captured value by up to SHIFT_STEP bits per cycle
// until the remaining shift amount is exhausted.
module serial_shifter
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] value_in,
  input  logic [4:0]       amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value_out
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [WIDTH-1:0] value;
  logic [4:0]       remaining;
  logic [4:0]       op_q;
  logic [4:0]       step;

  assign step = (remaining < STEP) ? remaining : STEP;
  assign busy = (remaining != 5'd0);
  // done flags the cycle whose step finishes the shift, so value_out is final then
  assign done = busy && (remaining <= STEP);

  always_comb begin
    value_out = value;
    case (op_q)
      ALU_SLL: value_out = value << step;
      ALU_SRL: value_out = value >> step;
      default: value_out = $signed(value) >>> step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value     <= '0;
      remaining <= 5'd0;
      op_q      <= ALU_NULL;
    end else if (start) begin
      value     <= value_in;
      remaining <= amount;
      op_q      <= op;
    end else if (busy) begin
      value     <= value_out;
      remaining <= remaining - step;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle arithmetic/logic ops plus a serial shifter,
// with valid/ready handshakes on the operation input and the result output.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_ctrl,
  input  logic             sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  state_t           state, state_next;
  logic [WIDTH-1:0] sum, diff, alu_res, load_res, sh_out;
  logic             alu_ovf, load_ovf, slt_bit;
  logic             take, is_shift, shamt_zero, load;
  logic             sh_start, sh_busy, sh_done;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;
  assign slt_bit = sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = sign && (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = sign && (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_AND: alu_res = in_a & in_b;
      ALU_OR:  alu_res = in_a | in_b;
      ALU_XOR: alu_res = in_a ^ in_b;
      ALU_NOR: alu_res = ~(in_a | in_b);
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_JR:  alu_res = in_a;
      ALU_LUI: alu_res = {in_b[15:0], 16'b0};
      default: alu_res = '0;
    endcase
  end

  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid  = (state == DONE);
  assign take       = in_valid && in_ready;
  assign is_shift   = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
  assign shamt_zero = (in_a[4:0] == 5'd0);
  assign sh_start   = take && is_shift && !shamt_zero;

  serial_shifter #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (sh_start),
    .op       (alu_ctrl),
    .value_in (in_b),
    .amount   (in_a[4:0]),
    .busy     (sh_busy),
    .done     (sh_done),
    .value_out(sh_out)
  );

  // A zero-length shift bypasses the shifter and completes like a single-cycle op
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_res   = alu_res;
    load_ovf   = alu_ovf;
    case (state)
      IDLE, DONE: begin
        if (take) begin
          state_next = DONE;
          load       = 1'b1;
          if (is_shift) begin
            load_ovf = 1'b0;
            load_res = in_b;
            if (!shamt_zero) begin
              load       = 1'b0;
              state_next = SHIFT;
            end
          end
        end else if ((state == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (sh_done || !sh_busy) begin
          load       = 1'b1;
          load_res   = sh_out;
          load_ovf   = 1'b0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        result <= load_res;
        zero   <= (load_res == '0);
        ovf    <= load_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases with literal expectations plus
// randomized traffic scored every cycle against a spec-level model.
`timescale 1ns/1ps
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int SHIFT_STEP = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_ctrl = 5'd0;
  logic        sign = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.SHIFT_STEP(SHIFT_STEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .sign     (sign),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Spec-level prediction; due holds the extra cycles spent shifting
  function automatic exp_t predict(input logic [4:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t   p;
    longint wide;
    int     sh;
    sh    = int'(a[4:0]);
    p.res = 32'd0;
    p.ovf = 1'b0;
    p.due = 0;
    case (op)
      ALU_ADD: begin
        p.res = a + b;
        wide  = longint'($signed(a)) + longint'($signed(b));
        p.ovf = sg && (wide != longint'($signed(p.res)));
      end
      ALU_SUB: begin
        p.res = a - b;
        wide  = longint'($signed(a)) - longint'($signed(b));
        p.ovf = sg && (wide != longint'($signed(p.res)));
      end
      ALU_AND: p.res = a & b;
      ALU_OR:  p.res = a | b;
      ALU_XOR: p.res = a ^ b;
      ALU_NOR: p.res = ~(a | b);
      ALU_SLL: begin p.res = b << sh; p.due = (sh + SHIFT_STEP - 1) / SHIFT_STEP; end
      ALU_SRL: begin p.res = b >> sh; p.due = (sh + SHIFT_STEP - 1) / SHIFT_STEP; end
      ALU_SRA: begin p.res = $signed(b) >>> sh; p.due = (sh + SHIFT_STEP - 1) / SHIFT_STEP; end
      ALU_SLT: p.res = sg ? (($signed(a) < $signed(b)) ? 32'd1 : 32'd0) : ((a < b) ? 32'd1 : 32'd0);
      ALU_JR:  p.res = a;
      ALU_LUI: p.res = b << 16;
      default: p.res = 32'd0;
    endcase
    p.zero = (p.res == 32'd0);
    return p;
  endfunction

  function automatic bit modelReady();
    return (q.size() == 0) || ((cyc >= q[0].due) && out_ready);
  endfunction

  function automatic logic [31:0] randOperand();
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Model update: retire on output handshake, enqueue on input handshake
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      bit   rdy;
      exp_t e;
      rdy = modelReady();
      if ((q.size() > 0) && (cyc >= q[0].due) && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        e     = predict(alu_ctrl, sign, in_a, in_b);
        e.due = cyc + 1 + e.due;
        q.push_back(e);
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      bit ev;
      ev = (q.size() > 0) && (cyc >= q[0].due);
      checkOutput("in_ready", in_ready, modelReady());
      checkOutput("out_valid", out_valid, ev);
      if (ev) begin
        checkOutput("result", result, q[0].res);
        checkOutput("zero", zero, q[0].zero);
        checkOutput("ovf", ovf, q[0].ovf);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic applyStimulus(input logic [4:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b,
                               input bit release_out, output int xfer, output int waits);
    @(posedge clk);
    #1;
    alu_ctrl = op;
    sign     = sg;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    if (release_out) out_ready = 1'b1;
    waits = 0;
    xfer  = -1;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: actual=no transfer required=transfer within 200 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    xfer     = cyc - 1;
    in_valid = 1'b0;
    alu_ctrl = 5'($urandom);
    sign     = 1'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic waitResult(input string name, input logic [31:0] er, input logic ez, input logic eo,
                            input int elat, input int xfer);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((out_valid !== 1'b1) && (n < 100));
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: actual=no out_valid required=out_valid within 100 cycles", name);
      return;
    end
    checkOutput({name, "_result"}, result, er);
    checkOutput({name, "_zero"}, zero, ez);
    checkOutput({name, "_ovf"}, ovf, eo);
    checkOutput({name, "_latency"}, cyc - xfer, elat);
  endtask

  initial begin
    int xfer;
    int waits;
    logic [4:0] op;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", zero, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    cmp_en = 1'b1;

    applyStimulus(ALU_ADD, 1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, xfer, waits);
    waitResult("add_signed", 32'h80000000, 1'b0, 1'b1, 1, xfer);
    applyStimulus(ALU_ADD, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, xfer, waits);
    waitResult("add_unsigned", 32'h80000000, 1'b0, 1'b0, 1, xfer);
    applyStimulus(ALU_SLT, 1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, xfer, waits);
    waitResult("slt_signed", 32'h1, 1'b0, 1'b0, 1, xfer);
    applyStimulus(ALU_SLT, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, xfer, waits);
    waitResult("slt_unsigned", 32'h0, 1'b1, 1'b0, 1, xfer);
    applyStimulus(ALU_SUB, 1'b1, 32'd5, 32'd5, 1'b0, xfer, waits);
    waitResult("sub_zero", 32'h0, 1'b1, 1'b0, 1, xfer);
    applyStimulus(ALU_SUB, 1'b1, 32'h80000000, 32'h1, 1'b0, xfer, waits);
    waitResult("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1, xfer);

    applyStimulus(ALU_SRA, 1'b0, 32'd4, 32'h80000000, 1'b0, xfer, waits);
    @(negedge clk);
    checkOutput("sra_busy_in_ready", in_ready, 1'b0);
    waitResult("sra", 32'hF8000000, 1'b0, 1'b0, 5, xfer);
    applyStimulus(ALU_SRL, 1'b1, 32'd8, 32'hF0000000, 1'b0, xfer, waits);
    waitResult("srl", 32'h00F00000, 1'b0, 1'b0, 9, xfer);
    applyStimulus(ALU_SLL, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, xfer, waits);
    waitResult("shift_zero", 32'hDEADBEEF, 1'b0, 1'b0, 1, xfer);
    applyStimulus(ALU_LUI, 1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b0, xfer, waits);
    waitResult("lui", 32'h12340000, 1'b0, 1'b0, 1, xfer);
    applyStimulus(5'd20, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, xfer, waits);
    waitResult("reserved", 32'h0, 1'b1, 1'b0, 1, xfer);

    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(ALU_XOR, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, xfer, waits);
    waitResult("bp_first", 32'h0FF00FF0, 1'b0, 1'b0, 1, xfer);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_hold_result", result, 32'h0FF00FF0);
      checkOutput("bp_hold_in_ready", in_ready, 1'b0);
      checkOutput("bp_hold_valid", out_valid, 1'b1);
    end
    applyStimulus(ALU_ADD, 1'b0, 32'd2, 32'd3, 1'b1, xfer, waits);
    checkOutput("bp_same_cycle_accept", waits, 32'd0);
    waitResult("bp_next", 32'd5, 1'b0, 1'b0, 1, xfer);

    applyStimulus(ALU_SLL, 1'b0, 32'd31, 32'h1, 1'b0, xfer, waits);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_out_valid", out_valid, 1'b0);
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_in_ready", in_ready, 1'b1);
    checkOutput("abort_zero", zero, 1'b0);
    applyStimulus(ALU_ADD, 1'b1, 32'd10, 32'd20, 1'b0, xfer, waits);
    waitResult("after_abort", 32'd30, 1'b0, 1'b0, 1, xfer);

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12));
      applyStimulus(op, 1'($urandom_range(0, 1)), randOperand(), randOperand(), 1'b0, xfer, waits);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
